fetch_ctrl: RTL and testbench

//  Fetch-stage sequencer between the instruction cache port and the fetch/decode interface.

---
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one I-cache request in flight and
// buffers returned instructions in a 2-entry FIFO toward decode.
module fetch_ctrl #(
    parameter int              ADDR     = 32,
    parameter int              INST     = 32,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ic_req,
    output logic [ADDR-1:0] ic_addr,
    input  logic            ic_ready,
    input  logic            ic_valid,
    input  logic [INST-1:0] ic_inst,
    input  logic            br_redirect,
    input  logic [ADDR-1:0] br_target,
    output logic            dec_valid,
    output logic [ADDR-1:0] dec_pc,
    output logic [INST-1:0] dec_inst,
    input  logic            dec_stall
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    localparam logic [ADDR-1:0] PC_STEP = ADDR'(INST / 8);

    state_t          state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [ADDR-1:0] req_pc_q, req_pc_d;
    logic            push;
    logic            pop;
    logic            req_ok;

    logic [ADDR-1:0] fifo_pc_q   [2];
    logic [INST-1:0] fifo_inst_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        req_ok   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (br_redirect) pc_d = br_target;
            end
            S_REQ: begin
                // Issue only with FIFO space so a returning response always fits.
                req_ok = (count_q != 2'd2) && !br_redirect;
                if (br_redirect) begin
                    pc_d = br_target;
                end else if (req_ok && ic_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_redirect) begin
                    pc_d    = br_target;
                    state_d = ic_valid ? S_REQ : S_DROP;
                end else if (ic_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (br_redirect) pc_d = br_target;
                if (ic_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ic_req  = req_ok;
    assign ic_addr = pc_q;

    assign dec_valid = (count_q != 2'd0);
    assign dec_pc    = fifo_pc_q[rd_ptr_q];
    assign dec_inst  = fifo_inst_q[rd_ptr_q];
    assign pop       = dec_valid && !dec_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (br_redirect) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= req_pc_q;
                fifo_inst_q[wr_ptr_q] <= ic_inst;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, stall, redirects and PC wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_ready, ic_valid, br_redirect, dec_stall;
    logic [31:0] ic_inst, br_target;
    logic        ic_req, dec_valid, ic_req2, dec_valid2;
    logic [31:0] ic_addr, dec_pc, dec_inst, ic_addr2, dec_pc2, dec_inst2;

    int checks   = 0;
    int failures = 0;
    logic        auto_resp;
    logic        acc;
    logic [31:0] acc_addr;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_ready(ic_ready), .ic_valid(ic_valid), .ic_inst(ic_inst),
        .br_redirect(br_redirect), .br_target(br_target),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
        .dec_stall(dec_stall)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .ic_req(ic_req2), .ic_addr(ic_addr2),
        .ic_ready(ic_ready), .ic_valid(ic_valid), .ic_inst(ic_inst),
        .br_redirect(br_redirect), .br_target(br_target),
        .dec_valid(dec_valid2), .dec_pc(dec_pc2), .dec_inst(dec_inst2),
        .dec_stall(dec_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: a 1-cycle I-cache answers each accepted request on the next cycle.
    task automatic tick();
        #1;
        acc      = ic_req && ic_ready;
        acc_addr = ic_addr;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            ic_valid = acc;
            ic_inst  = 32'h13 + acc_addr;
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ic_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ic_ready = 1'b0; ic_valid = 1'b0; ic_inst = '0;
        br_redirect = 1'b0; br_target = '0; dec_stall = 1'b0; auto_resp = 1'b0;

        // 1: reset held 3 cycles, first request one cycle after release
        repeat (3) tick();
        check("rst_ic_req", 32'(ic_req), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_ic_addr", ic_addr, 32'h0);
        reset = 1'b0;
        #1;
        check("idle_ic_req", 32'(ic_req), 32'd0);
        tick();
        check("first_ic_req", 32'(ic_req), 32'd1);
        check("first_ic_addr", ic_addr, 32'h0);

        // 2: streaming, one instruction every two cycles
        ic_ready = 1'b1; auto_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stream_wait_req", 32'(ic_req), 32'd0);
            tick();
            check("stream_valid", 32'(dec_valid), 32'd1);
            check("stream_pc", dec_pc, 32'(4 * k));
            check("stream_inst", dec_inst, 32'h13 + 32'(4 * k));
        end

        // 3: decode stall fills the FIFO and blocks issue
        do_reset();
        dec_stall = 1'b1;
        repeat (10) tick();
        check("stall_valid", 32'(dec_valid), 32'd1);
        check("stall_pc", dec_pc, 32'h0);
        check("stall_inst", dec_inst, 32'h13);
        check("stall_ic_req", 32'(ic_req), 32'd0);
        dec_stall = 1'b0;
        tick();
        check("unstall_pc", dec_pc, 32'h4);
        check("unstall_ic_req", 32'(ic_req), 32'd1);
        check("unstall_ic_addr", ic_addr, 32'h8);
        tick();
        check("unstall_empty", 32'(dec_valid), 32'd0);

        // 4: redirect while waiting, stale response arrives two cycles later
        do_reset();
        tick();
        auto_resp = 1'b0;
        ic_valid = 1'b0;
        br_redirect = 1'b1; br_target = 32'h100;
        tick();
        br_redirect = 1'b0;
        check("drop_ic_req", 32'(ic_req), 32'd0);
        tick();
        ic_valid = 1'b1; ic_inst = 32'hDEAD;
        #1;
        check("drop_ic_req2", 32'(ic_req), 32'd0);
        tick();
        ic_valid = 1'b0;
        check("drop_dec_valid", 32'(dec_valid), 32'd0);
        check("drop_ic_req3", 32'(ic_req), 32'd1);
        check("drop_ic_addr", ic_addr, 32'h100);
        auto_resp = 1'b1;
        tick();
        check("drop_no_stale", 32'(dec_valid), 32'd0);
        tick();
        check("redir_pc", dec_pc, 32'h100);
        check("redir_inst", dec_inst, 32'h113);

        // 5: redirect coincides with a response while one entry is buffered
        do_reset();
        dec_stall = 1'b1;
        tick(); tick(); tick();
        check("pre_flush_valid", 32'(dec_valid), 32'd1);
        check("pre_flush_icv", 32'(ic_valid), 32'd1);
        dec_stall = 1'b0;
        br_redirect = 1'b1; br_target = 32'h200;
        tick();
        br_redirect = 1'b0;
        #1;
        check("flush_empty", 32'(dec_valid), 32'd0);
        check("flush_ic_req", 32'(ic_req), 32'd1);
        check("flush_ic_addr", ic_addr, 32'h200);
        tick(); tick();
        check("flush_next_pc", dec_pc, 32'h200);

        // 6: PC wrap and reset while a request is outstanding
        do_reset();
        check("wrap_first_addr", ic_addr2, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_second_addr", ic_addr2, 32'h0);
        check("wrap_dec_pc", dec_pc2, 32'hFFFF_FFFC);
        tick();
        auto_resp = 1'b0;
        ic_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("async_rst_addr", ic_addr2, 32'hFFFF_FFFC);
        check("async_rst_valid", 32'(dec_valid2), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_wait_req", 32'(ic_req2), 32'd1);
        check("rst_wait_addr", ic_addr2, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
